// File: rtl/reservation_station_mul_pipe.sv
// reservation_station_mul_pipe: multiply reservation station with tag
// wakeup, oldest-ready issue and a stallable multiplier pipeline.
module reservation_station_mul_pipe #(
  parameter int DEPTH    = 8,
  parameter int VREG_W   = 5,
  parameter int WB_PORTS = 3,
  parameter int MUL_LAT  = 3,
  localparam int IW      = $clog2(DEPTH),
  localparam int CW      = IW + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_en,
  input  logic [2:0]                 op_type,
  input  logic [VREG_W-1:0]          vdest_id,
  input  logic [4:0]                 dest_reg,
  input  logic                       op1_dependent,
  input  logic                       op2_dependent,
  input  logic [31:0]                op1,
  input  logic [31:0]                op2,
  input  logic [WB_PORTS-1:0]        wb_en,
  input  logic [WB_PORTS*VREG_W-1:0] wb_vregid,
  input  logic [WB_PORTS*32-1:0]     wb_val,
  input  logic                       out_ready,
  output logic                       writeback_en,
  output logic [VREG_W-1:0]          writeback_vregid,
  output logic [4:0]                 writeback_dest,
  output logic [31:0]                writeback_val,
  output logic                       full,
  output logic [CW-1:0]              count
);

  logic [DEPTH-1:0]  e_v, e_p1, e_p2;
  logic [31:0]       e_a    [DEPTH];
  logic [31:0]       e_b    [DEPTH];
  logic [1:0]        e_op   [DEPTH];
  logic [VREG_W-1:0] e_vreg [DEPTH];
  logic [4:0]        e_dest [DEPTH];
  // older[i][j] set when entry j was inserted before entry i
  logic [DEPTH-1:0]  older  [DEPTH];

  logic [32:0]       w1 [DEPTH];
  logic [32:0]       w2 [DEPTH];
  logic [32:0]       in_w1, in_w2;
  logic              in_p1, in_p2;
  logic [31:0]       in_a, in_b;
  logic [1:0]        in_op;
  logic [DEPTH-1:0]  rdy;
  logic [IW-1:0]     sel_idx, free_idx;
  logic              stall, issue_ent, accept, direct, ins;

  logic              iss_v;
  logic [31:0]       iss_a, iss_b;
  logic [1:0]        iss_op;
  logic [VREG_W-1:0] iss_vreg;
  logic [4:0]        iss_dest;

  logic              s0_v;
  logic [31:0]       s0_a, s0_b;
  logic [1:0]        s0_op;
  logic [VREG_W-1:0] s0_vreg;
  logic [4:0]        s0_dest;

  logic [MUL_LAT-1:0] r_v;
  logic [31:0]        r_val  [MUL_LAT];
  logic [VREG_W-1:0]  r_vreg [MUL_LAT];
  logic [4:0]         r_dest [MUL_LAT];

  logic        sa, sb;
  logic [63:0] ma, mb, prod;
  logic [31:0] res;

  // Lowest-index matching port wins, so scan from the top down.
  function automatic logic [32:0] wake(
    input logic [VREG_W-1:0]          tag,
    input logic [WB_PORTS-1:0]        en,
    input logic [WB_PORTS*VREG_W-1:0] ids,
    input logic [WB_PORTS*32-1:0]     vals
  );
    logic [32:0] r;
    r = '0;
    for (int k = WB_PORTS - 1; k >= 0; k--) begin
      if (en[k] && ids[k*VREG_W +: VREG_W] == tag) begin
        r = {1'b1, vals[k*32 +: 32]};
      end
    end
    return r;
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign in_op  = op_type[2] ? 2'b00 : op_type[1:0];
  assign rdy    = e_v & ~e_p1 & ~e_p2;
  assign stall  = writeback_en & ~out_ready;

  always_comb begin
    in_w1 = wake(op1[VREG_W-1:0], wb_en, wb_vregid, wb_val);
    in_w2 = wake(op2[VREG_W-1:0], wb_en, wb_vregid, wb_val);
    in_p1 = op1_dependent & ~in_w1[32];
    in_p2 = op2_dependent & ~in_w2[32];
    in_a  = (op1_dependent & in_w1[32]) ? in_w1[31:0] : op1;
    in_b  = (op2_dependent & in_w2[32]) ? in_w2[31:0] : op2;
    for (int i = 0; i < DEPTH; i++) begin
      w1[i] = wake(e_a[i][VREG_W-1:0], wb_en, wb_vregid, wb_val);
      w2[i] = wake(e_b[i][VREG_W-1:0], wb_en, wb_vregid, wb_val);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !(|(rdy & older[i]))) sel_idx = IW'(i);
    end
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_v[i]) free_idx = IW'(i);
    end
  end

  assign issue_ent = (|rdy) & ~stall;
  assign accept    = in_en & ~full;
  assign direct    = accept & ~(|rdy) & ~in_p1 & ~in_p2 & ~stall;
  assign ins       = accept & ~direct;

  always_comb begin
    iss_v    = issue_ent | direct;
    iss_a    = issue_ent ? e_a[sel_idx]    : in_a;
    iss_b    = issue_ent ? e_b[sel_idx]    : in_b;
    iss_op   = issue_ent ? e_op[sel_idx]   : in_op;
    iss_vreg = issue_ent ? e_vreg[sel_idx] : vdest_id;
    iss_dest = issue_ent ? e_dest[sel_idx] : dest_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_v   <= '0;
      e_p1  <= '0;
      e_p2  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_a[i]    <= '0;
        e_b[i]    <= '0;
        e_op[i]   <= '0;
        e_vreg[i] <= '0;
        e_dest[i] <= '0;
        older[i]  <= '0;
      end
    end else if (flush) begin
      e_v   <= '0;
      count <= '0;
    end else begin
      count <= count + CW'(ins) - CW'(issue_ent);
      for (int i = 0; i < DEPTH; i++) begin
        if (e_v[i] && e_p1[i] && w1[i][32]) begin
          e_p1[i] <= 1'b0;
          e_a[i]  <= w1[i][31:0];
        end
        if (e_v[i] && e_p2[i] && w2[i][32]) begin
          e_p2[i] <= 1'b0;
          e_b[i]  <= w2[i][31:0];
        end
        if (issue_ent && sel_idx == IW'(i)) e_v[i] <= 1'b0;
        if (ins) older[i][free_idx] <= 1'b0;
      end
      if (ins) begin
        e_v[free_idx]    <= 1'b1;
        e_p1[free_idx]   <= in_p1;
        e_p2[free_idx]   <= in_p2;
        e_a[free_idx]    <= in_a;
        e_b[free_idx]    <= in_b;
        e_op[free_idx]   <= in_op;
        e_vreg[free_idx] <= vdest_id;
        e_dest[free_idx] <= dest_reg;
        older[free_idx]  <= e_v;
      end
    end
  end

  // Operand extension selects signedness; the low 64 bits are exact.
  always_comb begin
    sa   = (s0_op != 2'b11) & s0_a[31];
    sb   = ~s0_op[1] & s0_b[31];
    ma   = {{32{sa}}, s0_a};
    mb   = {{32{sb}}, s0_b};
    prod = ma * mb;
    res  = (s0_op == 2'b00) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v             <= 1'b0;
      s0_a             <= '0;
      s0_b             <= '0;
      s0_op            <= '0;
      s0_vreg          <= '0;
      s0_dest          <= '0;
      r_v              <= '0;
      writeback_en     <= 1'b0;
      writeback_vregid <= '0;
      writeback_dest   <= '0;
      writeback_val    <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        r_val[i]  <= '0;
        r_vreg[i] <= '0;
        r_dest[i] <= '0;
      end
    end else if (flush) begin
      s0_v         <= 1'b0;
      r_v          <= '0;
      writeback_en <= 1'b0;
    end else if (!stall) begin
      s0_v <= iss_v;
      if (iss_v) begin
        s0_a    <= iss_a;
        s0_b    <= iss_b;
        s0_op   <= iss_op;
        s0_vreg <= iss_vreg;
        s0_dest <= iss_dest;
      end
      r_v[0] <= s0_v;
      if (s0_v) begin
        r_val[0]  <= res;
        r_vreg[0] <= s0_vreg;
        r_dest[0] <= s0_dest;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        r_v[i]    <= r_v[i-1];
        r_val[i]  <= r_val[i-1];
        r_vreg[i] <= r_vreg[i-1];
        r_dest[i] <= r_dest[i-1];
      end
      writeback_en <= r_v[MUL_LAT-1];
      if (r_v[MUL_LAT-1]) begin
        writeback_val    <= r_val[MUL_LAT-1];
        writeback_vregid <= r_vreg[MUL_LAT-1];
        writeback_dest   <= r_dest[MUL_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_mul_pipe.sv
// tb_reservation_station_mul_pipe: directed and random checks against
// a queue-based reference model of the station and multiplier.
module tb_reservation_station_mul_pipe;
  localparam int D   = 8;
  localparam int LAT = 3;
  localparam int NS  = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_en = 1'b0;
  logic [2:0]  op_type = '0;
  logic [4:0]  vdest_id = '0;
  logic [4:0]  dest_reg = '0;
  logic        op1_dependent = 1'b0;
  logic        op2_dependent = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [2:0]  wb_en = '0;
  logic [14:0] wb_vregid = '0;
  logic [95:0] wb_val = '0;
  logic        out_ready = 1'b1;
  logic        writeback_en;
  logic [4:0]  writeback_vregid;
  logic [4:0]  writeback_dest;
  logic [31:0] writeback_val;
  logic        full;
  logic [3:0]  count;

  reservation_station_mul_pipe #(
    .DEPTH(D), .VREG_W(5), .WB_PORTS(3), .MUL_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_en(in_en),
    .op_type(op_type), .vdest_id(vdest_id), .dest_reg(dest_reg),
    .op1_dependent(op1_dependent), .op2_dependent(op2_dependent),
    .op1(op1), .op2(op2), .wb_en(wb_en), .wb_vregid(wb_vregid),
    .wb_val(wb_val), .out_ready(out_ready),
    .writeback_en(writeback_en), .writeback_vregid(writeback_vregid),
    .writeback_dest(writeback_dest), .writeback_val(writeback_val),
    .full(full), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        p1, p2;
    bit [31:0] a, b;
    bit [2:0]  op;
    bit [4:0]  vreg, dest;
  } ent_t;

  typedef struct {
    bit        v;
    bit [4:0]  vreg, dest;
    bit [31:0] val;
  } res_t;

  ent_t rs[$];
  res_t pipe [NS];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [2:0]  ops3 [4] = '{3'd3, 3'd1, 3'd2, 3'd0};
  logic [31:0] exp3 [4] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h1};

  function automatic bit [31:0] ref_mul(bit [2:0] op, bit [31:0] a, bit [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd1:    p = 64'(sa * sb);
      3'd2:    p = 64'(sa) * ub;
      3'd3:    p = ua * ub;
      default: p = ua * ub;
    endcase
    return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic bit [32:0] bypass(bit [4:0] tag);
    for (int k = 0; k < 3; k++) begin
      if (wb_en[k] && wb_vregid[k*5 +: 5] == tag) return {1'b1, wb_val[k*32 +: 32]};
    end
    return '0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rs.delete();
    for (int i = 0; i < NS; i++) begin
      pipe[i].v = 0; pipe[i].vreg = 0; pipe[i].dest = 0; pipe[i].val = 0;
    end
  endtask

  task automatic model_step();
    ent_t    ne;
    res_t    iss;
    bit [32:0] w;
    int      idx;
    bit      stall, accept, dir;
    if (flush) begin
      rs.delete();
      for (int i = 0; i < NS; i++) pipe[i].v = 0;
      return;
    end
    stall  = pipe[NS-1].v && !out_ready;
    accept = in_en && (rs.size() < D);
    ne.op = op_type; ne.vreg = vdest_id; ne.dest = dest_reg;
    w = bypass(op1[4:0]);
    ne.p1 = op1_dependent && !w[32];
    ne.a  = (op1_dependent && w[32]) ? w[31:0] : op1;
    w = bypass(op2[4:0]);
    ne.p2 = op2_dependent && !w[32];
    ne.b  = (op2_dependent && w[32]) ? w[31:0] : op2;
    idx = -1;
    foreach (rs[i]) if (idx < 0 && !rs[i].p1 && !rs[i].p2) idx = i;
    iss.v = 0; iss.vreg = 0; iss.dest = 0; iss.val = 0;
    dir = 0;
    if (!stall && idx >= 0) begin
      iss.v = 1; iss.vreg = rs[idx].vreg; iss.dest = rs[idx].dest;
      iss.val = ref_mul(rs[idx].op, rs[idx].a, rs[idx].b);
      rs.delete(idx);
    end else if (!stall && accept && idx < 0 && !ne.p1 && !ne.p2) begin
      dir = 1;
      iss.v = 1; iss.vreg = ne.vreg; iss.dest = ne.dest;
      iss.val = ref_mul(ne.op, ne.a, ne.b);
    end
    foreach (rs[i]) begin
      if (rs[i].p1) begin
        w = bypass(rs[i].a[4:0]);
        if (w[32]) begin rs[i].p1 = 0; rs[i].a = w[31:0]; end
      end
      if (rs[i].p2) begin
        w = bypass(rs[i].b[4:0]);
        if (w[32]) begin rs[i].p2 = 0; rs[i].b = w[31:0]; end
      end
    end
    if (accept && !dir) rs.push_back(ne);
    if (!stall) begin
      for (int i = NS - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = iss;
    end
  endtask

  task automatic check_outputs();
    chk("wb_en", 64'(writeback_en), 64'(pipe[NS-1].v));
    if (pipe[NS-1].v) begin
      chk("wb_vreg", 64'(writeback_vregid), 64'(pipe[NS-1].vreg));
      chk("wb_dest", 64'(writeback_dest), 64'(pipe[NS-1].dest));
      chk("wb_val", 64'(writeback_val), 64'(pipe[NS-1].val));
    end
    chk("count", 64'(count), 64'(rs.size()));
    chk("full", 64'(full), 64'(rs.size() == D));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    in_en = 0; flush = 0; op1_dependent = 0; op2_dependent = 0;
    wb_en = '0; out_ready = 1; op_type = '0;
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_en"}, 64'(writeback_en), 64'(0));
    chk({tag, "_cnt"}, 64'(count), 64'(0));
    chk({tag, "_full"}, 64'(full), 64'(0));
    chk({tag, "_val"}, 64'(writeback_val), 64'(0));
    chk({tag, "_vreg"}, 64'(writeback_vregid), 64'(0));
    chk({tag, "_dest"}, 64'(writeback_dest), 64'(0));
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 5)
      0:       return 32'hFFFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] t;
    model_reset();
    #1 rst_n = 0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // single direct-issue multiply
    in_en = 1; op_type = 3'd0; op1 = 7; op2 = 6; vdest_id = 3; dest_reg = 10;
    cycle();
    idle();
    repeat (3) begin
      cycle();
      chk("t22_early", 64'(writeback_en), 64'(0));
    end
    cycle();
    chk("t22_en", 64'(writeback_en), 64'(1));
    chk("t22_val", 64'(writeback_val), 64'(42));
    chk("t22_vreg", 64'(writeback_vregid), 64'(3));
    chk("t22_dest", 64'(writeback_dest), 64'(10));
    repeat (3) cycle();

    // high-half variants on all-ones operands
    for (int i = 0; i < 4; i++) begin
      in_en = 1; op_type = ops3[i]; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
      vdest_id = 5'(11 + i); dest_reg = 5'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t23_val", 64'(writeback_val), 64'(exp3[i]));
    end
    repeat (3) cycle();

    // insert-cycle bypass from wb port 1
    in_en = 1; op_type = 0; op1_dependent = 1; op1 = 5; op2 = 4;
    vdest_id = 7; dest_reg = 2;
    wb_en = 3'b010; wb_vregid = {5'd0, 5'd5, 5'd0}; wb_val = {32'd0, 32'd3, 32'd0};
    cycle();
    idle();
    repeat (3) cycle();
    cycle();
    chk("t24_en", 64'(writeback_en), 64'(1));
    chk("t24_val", 64'(writeback_val), 64'(12));
    repeat (3) cycle();

    // three waiters on one producer drain oldest first
    for (int i = 0; i < 3; i++) begin
      in_en = 1; op_type = 0; op1_dependent = 1; op1 = 9; op2 = 32'(2 + i);
      vdest_id = 5'(20 + i); dest_reg = 5'(i);
      cycle();
    end
    idle();
    wb_en = 3'b001; wb_vregid = 15'd9; wb_val = 96'd10;
    cycle();
    idle();
    repeat (4) cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t25_en", 64'(writeback_en), 64'(1));
      chk("t25_vreg", 64'(writeback_vregid), 64'(20 + i));
      chk("t25_val", 64'(writeback_val), 64'(10 * (2 + i)));
    end
    repeat (3) cycle();

    // fill, reject, wake one
    for (int i = 0; i < 8; i++) begin
      in_en = 1; op_type = 0; op1_dependent = 1; op1 = 32'(16 + i);
      op2 = 32'(i + 1); vdest_id = 5'(i); dest_reg = 5'(i);
      cycle();
    end
    chk("t26_full", 64'(full), 64'(1));
    chk("t26_cnt8", 64'(count), 64'(8));
    op1_dependent = 0; op1 = 1; op2 = 1; vdest_id = 30;
    cycle();
    chk("t26_ign", 64'(count), 64'(8));
    idle();
    wb_en = 3'b100; wb_vregid = {5'd16, 5'd0, 5'd0}; wb_val = {32'd100, 64'd0};
    cycle();
    chk("t26_wake", 64'(count), 64'(8));
    idle();
    cycle();
    chk("t26_cnt7", 64'(count), 64'(7));
    chk("t26_nfull", 64'(full), 64'(0));
    for (int k = 17; k < 24; k++) begin
      wb_en = 3'b001; wb_vregid = 15'(k); wb_val = 96'(k);
      cycle();
    end
    idle();
    repeat (14) cycle();
    chk("t26_empty", 64'(count), 64'(0));

    // backpressure then flush
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_en = 1; op_type = 0; op1 = 32'(5 + i); op2 = 5;
      vdest_id = 5'(i + 1); dest_reg = 5'(i + 4);
      cycle();
    end
    in_en = 0;
    cycle();
    cycle();
    chk("t27_en", 64'(writeback_en), 64'(1));
    chk("t27_val", 64'(writeback_val), 64'(25));
    in_en = 1; op1_dependent = 1; op1 = 31; vdest_id = 9;
    cycle();
    in_en = 0; op1_dependent = 0;
    repeat (3) begin
      cycle();
      chk("t27_hold_en", 64'(writeback_en), 64'(1));
      chk("t27_hold_val", 64'(writeback_val), 64'(25));
      chk("t27_hold_vreg", 64'(writeback_vregid), 64'(1));
      chk("t27_hold_dest", 64'(writeback_dest), 64'(4));
    end
    chk("t27_cnt1", 64'(count), 64'(1));
    flush = 1;
    cycle();
    idle();
    chk("t27_fl_en", 64'(writeback_en), 64'(0));
    chk("t27_fl_cnt", 64'(count), 64'(0));
    repeat (6) cycle();

    // reset in the middle of operation
    in_en = 1; op1 = 3; op2 = 3; vdest_id = 1;
    cycle();
    in_en = 1; op1_dependent = 1; op1 = 2; vdest_id = 2;
    cycle();
    idle();
    cycle();
    rst_n = 0;
    model_reset();
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1;
    repeat (8) cycle();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_en = ($urandom % 3) != 0;
      op_type = 3'($urandom);
      vdest_id = 5'($urandom);
      dest_reg = 5'($urandom);
      op1_dependent = ($urandom % 3) == 0;
      op2_dependent = ($urandom % 3) == 0;
      t = rnd32();
      if (op1_dependent) t[4:0] = 5'($urandom_range(0, 7));
      op1 = t;
      t = rnd32();
      if (op2_dependent) t[4:0] = 5'($urandom_range(0, 7));
      op2 = t;
      wb_en = 3'($urandom);
      for (int k = 0; k < 3; k++) wb_vregid[k*5 +: 5] = 5'($urandom_range(0, 7));
      wb_val = {rnd32(), rnd32(), rnd32()};
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 128) == 0;
      cycle();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      wb_en = 3'b111;
      wb_vregid = {5'(k), 5'(k), 5'(k)};
      wb_val = 96'(k);
      cycle();
    end
    idle();
    repeat (20) cycle();
    chk("rand_drain", 64'(count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
